// File: rtl/mem_pkg.sv
// Shared definitions for the memory subsystem.
// Holds the default geometry used by both `memory` and `memory_requester`,
// and the state encoding of the requester FSM.
package mem_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_MEM_SIZE      = 128;
  localparam int DEF_MEM_ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/memory.sv
// Single-port synchronous word memory.
// Ports:
//   clock, reset            : system clock, synchronous active-high reset (clears contents)
//   read_enable, write_enable: access strobes sampled on posedge
//   address, data_in        : access address and store data
//   data_out                : registered read data, valid the cycle after read_enable is sampled
module memory
  import mem_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_SIZE      = DEF_MEM_SIZE,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read_enable,
  input  logic                     write_enable,
  input  logic [MEM_ADDR_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0]     data_in,
  output logic [WORD_SIZE-1:0]     data_out
);

  localparam int IDX_W = $clog2(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
  logic [WORD_SIZE-1:0] data_out_q;
  logic                 in_range;
  logic [IDX_W-1:0]     idx;

  assign in_range = int'(address) < MEM_SIZE;
  assign idx      = address[IDX_W-1:0];
  assign data_out = data_out_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
      data_out_q <= '0;
    end else begin
      if (write_enable && in_range) mem_q[idx] <= data_in;
      if (read_enable) data_out_q <= in_range ? mem_q[idx] : '0;
    end
  end

endmodule

// File: rtl/memory_requester.sv
// Initiator-side master for the single-port `memory` block.
// Accepts one load/store at a time over a valid/ready handshake, sequences
// the memory strobes and returns a single-cycle response.
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only while idle)
//   req_write, req_addr, req_wdata: request contents (1 = store)
//   resp_valid/resp_rdata/resp_error: one-cycle response, no backpressure
//   mem_*                        : strobes/address/data to and from `memory`
// All outputs come straight from flops.
module memory_requester
  import mem_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_SIZE      = DEF_MEM_SIZE,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [MEM_ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]     req_wdata,
  output logic                     resp_valid,
  output logic [WORD_SIZE-1:0]     resp_rdata,
  output logic                     resp_error,
  output logic                     mem_read_enable,
  output logic                     mem_write_enable,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_data_in,
  input  logic [WORD_SIZE-1:0]     mem_data_out
);

  state_e                   state_q, state_d;
  logic                     req_ready_q, req_ready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_error_q, resp_error_d;
  logic [WORD_SIZE-1:0]     resp_rdata_q, resp_rdata_d;
  logic                     mem_re_q, mem_re_d;
  logic                     mem_we_q, mem_we_d;
  logic [MEM_ADDR_SIZE-1:0] mem_address_q, mem_address_d;
  logic [WORD_SIZE-1:0]     mem_data_in_q, mem_data_in_d;

  logic accept;
  logic addr_ok;

  assign accept  = req_valid && req_ready_q;
  assign addr_ok = int'(req_addr) < MEM_SIZE;

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!addr_ok)       state_d = ST_RESP;
          else if (req_write) state_d = ST_WRITE;
          else                state_d = ST_READ;
        end
      end
      ST_WRITE:   state_d = ST_RESP;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: each registered output is a function of the state being
  // entered, so it is valid for exactly the cycle spent in that state.
  always_comb begin
    req_ready_d   = (state_d == ST_IDLE);
    mem_re_d      = (state_d == ST_READ);
    mem_we_d      = (state_d == ST_WRITE);
    resp_valid_d  = (state_d == ST_RESP);
    // Only an out-of-range request jumps from IDLE straight to RESP.
    resp_error_d  = (state_d == ST_RESP) && (state_q == ST_IDLE);
    resp_rdata_d  = resp_rdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;

    // Address/data only move for real accesses so the bus stays quiet otherwise.
    if (state_q == ST_IDLE && accept && addr_ok) begin
      mem_address_d = req_addr;
      if (req_write) mem_data_in_d = req_wdata;
    end

    // Read data is sampled at the end of CAPTURE; stores and errors answer 0.
    if (state_q == ST_CAPTURE)     resp_rdata_d = mem_data_out;
    else if (state_d == ST_RESP)   resp_rdata_d = '0;
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;

endmodule

// File: doc/memory_requester.md
Name: memory_requester

Overview:
Initiator-side master for the single-port synchronous `memory` block. It accepts one load/store request at a time from the core over a valid/ready handshake and drives `memory`'s read_enable, write_enable, address and data_in. For loads it captures data_out at the correct cycle. It returns a one-cycle response pulse with read data or an out-of-range error. It sits between the datapath and `memory` in the binary processor.

Parameters:
WORD_SIZE, 16, data word width
MEM_SIZE, 128, number of valid words; addresses >= MEM_SIZE are errors
MEM_ADDR_SIZE, 8, address width

Ports:
clock  in  1  single system clock, all state on posedge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
req_valid  in  1  core request present
req_ready  out  1  requester can accept; high only in IDLE
req_write  in  1  1=store, 0=load
req_addr  in  MEM_ADDR_SIZE  request word address
req_wdata  in  WORD_SIZE  store data
resp_valid  out  1  one-cycle response pulse, no backpressure
resp_rdata  out  WORD_SIZE  load data; 0 for stores and errors
resp_error  out  1  qualifies resp_valid; address out of range
mem_read_enable  out  1  to memory read_enable
mem_write_enable  out  1  to memory write_enable
mem_address  out  MEM_ADDR_SIZE  to memory address
mem_data_in  out  WORD_SIZE  to memory data_in
mem_data_out  in  WORD_SIZE  from memory data_out; registered one edge after read_enable is sampled

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_error=0, resp_rdata=0.
  - mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_data_in=0.
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
- Accept: a request is accepted at posedge edge E0 when req_valid && req_ready. At E0:
  - latch addr, wdata and write;
  - drive req_ready to 0.
  - req_* inputs are ignored at all other times.
  - A request held while req_ready=0 is taken on the first IDLE edge.
- Range check at acceptance: if req_addr >= MEM_SIZE, go to RESP with resp_error=1 and resp_rdata=0. No memory enable is asserted for that request.
- Store, in range:
  - WRITE lasts one cycle, with mem_write_enable=1, mem_address=addr and mem_data_in=wdata. mem_read_enable stays 0.
  - Then RESP with resp_valid=1, resp_error=0, resp_rdata=0.
  - resp_valid is high in the 2nd cycle after E0.
- Load, in range:
  - READ lasts one cycle with mem_read_enable=1 and mem_address=addr.
  - CAPTURE lasts one cycle. mem_data_out is valid here, and at the closing edge resp_rdata <= mem_data_out.
  - Then RESP. resp_valid is high in the 3rd cycle after E0.
- Enables are never asserted together. Each enable is high for exactly one cycle per request.
- mem_address and mem_data_in hold their last values outside accesses (no glitching to 0).
- RESP lasts one cycle: resp_valid=1, then IDLE with req_ready=1 on the next cycle.
  - Throughput is 1 load per 4 cycles and 1 store per 3 cycles.
  - resp_valid and resp_error return to 0 after RESP. resp_rdata holds until the next response.
- Reset asserted in any state: the next edge returns to IDLE and clears all outputs to their reset values.
  - An in-flight request is dropped with no response.
  - A write in the WRITE cycle during reset is not guaranteed; memory's own reset clears contents anyway.
- Address boundaries: 127 is valid; 128..255 are errors.

Decomposition:
- Shared package/header mem_pkg:
  - WORD_SIZE, MEM_SIZE and MEM_ADDR_SIZE defaults, shared with `memory`;
  - FSM state encoding constants (IDLE=0, WRITE=1, READ=2, CAPTURE=3, RESP=4, 3 bits).
- No sub-module; a single FSM plus datapath registers.
- The bench instantiates memory_requester connected to `memory`.

Test Plan:
1. Store addr 10 data ABCD, then load addr 10 -> store resp_valid 2 cycles after accept with error=0; load resp_rdata=ABCD 3 cycles after accept; exactly one mem_write_enable pulse and one mem_read_enable pulse.
2. Stores to 20/21/22 (1234/5678/9ABC), then loads of 20/21/22, with req_valid held high back-to-back -> reads 1234, 5678, 9ABC; req_ready low except in IDLE; no enable overlap.
3. Load addr 40 after reset -> resp_rdata=0000, error=0.
4. Store 127=9999 then load 127 -> 9999. Load addr 128 and store addr 200 -> resp_error=1, rdata=0000, no mem enable ever asserted.
5. Store 30=DEAD then store 30=BEEF, then load 30 -> BEEF.
6. Accept a load of addr 10, assert reset in the CAPTURE cycle -> no resp_valid; all outputs 0 next edge; req_ready=1; subsequent load of 10 returns 0000 (memory also reset).
